// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex keypad (Pmod KYPD style), debounces the
// scan results and encodes the pressed key into a 4-bit hex code.
//
// Ports:
//   ClkIn    in   board clock, all logic on the rising edge
//   Rst      in   synchronous active-high reset
//   Row[3:0] in   keypad rows, active-low, asynchronous to ClkIn
//   Col[3:0] out  column drive, active-low one-hot
//   Key[3:0] out  hex code of the last accepted key
//   KeyValid out  one-cycle strobe when Key is updated (or repeated)
//   KeyHeld  out  high while the accepted key is still debounced-pressed
//
// Optional feature macro: KEYPAD_REPEAT_EN
//   When defined, a held key re-strobes KeyValid every RepeatScans scans.
module keypad_scanner #(
  parameter int ScanDiv       = 100000,
  parameter int Bits          = 17,
  parameter int DebounceScans = 4,
  parameter int RepeatScans   = 64
) (
  input  logic       ClkIn,
  input  logic       Rst,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] Key,
  output logic       KeyValid,
  output logic       KeyHeld
);

  localparam bit ParamsOk = (ScanDiv >= 1) && ((64'd1 << Bits) >= 64'(ScanDiv)) &&
                            (DebounceScans >= 1) && (DebounceScans <= 15) &&
                            (RepeatScans >= 1) && (RepeatScans <= 255);

  generate
    if (!ParamsOk) begin : g_param_check
      $error("keypad_scanner: parameter out of range");
    end
  endgenerate

  localparam logic [Bits-1:0] DivLast = Bits'(ScanDiv - 1);
  localparam logic [3:0]      DebN    = 4'(DebounceScans);
  localparam bit              DebOne  = (DebounceScans == 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } state_t;

  // Key code at column c, row r of the keypad matrix.
  function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] code;
    case ({c, r})
      4'h0: code = 4'h1;  4'h1: code = 4'h4;  4'h2: code = 4'h7;  4'h3: code = 4'h0;
      4'h4: code = 4'h2;  4'h5: code = 4'h5;  4'h6: code = 4'h8;  4'h7: code = 4'hF;
      4'h8: code = 4'h3;  4'h9: code = 4'h6;  4'hA: code = 4'h9;  4'hB: code = 4'hE;
      4'hC: code = 4'hA;  4'hD: code = 4'hB;  4'hE: code = 4'hC;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Active-low one-hot drive pattern for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] c);
    logic [3:0] drv;
    case (c)
      2'd0:    drv = 4'b1110;
      2'd1:    drv = 4'b1101;
      2'd2:    drv = 4'b1011;
      2'd3:    drv = 4'b0111;
      default: drv = 4'b1110;
    endcase
    return drv;
  endfunction

  logic [3:0]      row_meta_r, row_sync_r;
  logic [Bits-1:0] div_r;
  logic [1:0]      col_idx_r;
  logic [3:0]      col_r;
  logic [1:0]      acc_cnt_r;   // low bits seen so far this scan, saturates at 2
  logic [3:0]      acc_code_r;
  logic            tick_s, scan_tick_s;
  logic [2:0]      col_cnt_s, sum_s;
  logic [3:0]      col_code_s;
  logic [1:0]      tot_cnt_s;
  logic [3:0]      tot_code_s;
  logic            single_s, same_s, at_deb_s;
  logic [3:0]      cnt_inc_s;

  state_t          state_r, state_s;
  logic [3:0]      cand_r, cand_s;
  logic [3:0]      cnt_r, cnt_s;
  logic [3:0]      key_r, key_s;
  logic            valid_r, valid_s;
  logic            held_r, held_s;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [7:0] RepN = 8'(RepeatScans);
  logic [7:0]      rep_r, rep_s;
`endif

  assign tick_s      = (div_r == DivLast);
  assign scan_tick_s = tick_s && (col_idx_r == 2'd3);

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge ClkIn) begin
    if (Rst) begin
      row_meta_r <= 4'b1111;
      row_sync_r <= 4'b1111;
    end else begin
      row_meta_r <= Row;
      row_sync_r <= row_meta_r;
    end
  end

  // Scan divider and column stepping; Col is updated together with the index.
  always_ff @(posedge ClkIn) begin
    if (Rst) begin
      div_r     <= '0;
      col_idx_r <= 2'd0;
      col_r     <= 4'b1110;
    end else if (tick_s) begin
      div_r     <= '0;
      col_idx_r <= col_idx_r + 2'd1;
      col_r     <= col_drive(col_idx_r + 2'd1);
    end else begin
      div_r     <= div_r + Bits'(1);
    end
  end

  // Count low rows in the current column and encode the pressed one.
  always_comb begin
    col_cnt_s  = 3'd0;
    col_code_s = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_r[r]) begin
        col_cnt_s  = col_cnt_s + 3'd1;
        col_code_s = key_code(col_idx_r, r[1:0]);
      end else begin
        col_cnt_s  = col_cnt_s;
      end
    end
  end

  // Merge this column into the running scan total (2 means MULTI).
  always_comb begin
    sum_s      = {1'b0, acc_cnt_r} + col_cnt_s;
    tot_cnt_s  = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
    tot_code_s = (acc_cnt_r == 2'd0) ? col_code_s : acc_code_r;
    single_s   = (tot_cnt_s == 2'd1);
    same_s     = (tot_code_s == cand_r);
    cnt_inc_s  = cnt_r + 4'd1;
    at_deb_s   = (cnt_inc_s >= DebN);
  end

  // Per-scan accumulator, cleared after the column-3 sample is evaluated.
  always_ff @(posedge ClkIn) begin
    if (Rst) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'h0;
    end else if (scan_tick_s) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'h0;
    end else if (tick_s) begin
      acc_cnt_r  <= tot_cnt_s;
      acc_code_r <= tot_code_s;
    end else begin
      acc_cnt_r  <= acc_cnt_r;
      acc_code_r <= acc_code_r;
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge ClkIn) begin
    if (Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Debounce FSM next-state logic; MULTI scans count as NONE.
  always_comb begin
    state_s = state_r;
    if (scan_tick_s) begin
      case (state_r)
        ST_IDLE: begin
          if (single_s) begin
            state_s = DebOne ? ST_HELD : ST_PRESS_DB;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_PRESS_DB: begin
          if (single_s && same_s && at_deb_s) begin
            state_s = ST_HELD;
          end else if (single_s) begin
            state_s = ST_PRESS_DB;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (single_s) begin
            state_s = ST_HELD;
          end else begin
            state_s = DebOne ? ST_IDLE : ST_REL_DB;
          end
        end
        ST_REL_DB: begin
          if (single_s) begin
            state_s = ST_HELD;
          end else if (at_deb_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_REL_DB;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Debounce FSM outputs: candidate/counters and next values of the outputs.
  always_comb begin
    cand_s  = cand_r;
    cnt_s   = cnt_r;
    key_s   = key_r;
    valid_s = 1'b0;
    held_s  = held_r;
`ifdef KEYPAD_REPEAT_EN
    rep_s   = rep_r;
`endif
    if (scan_tick_s) begin
      case (state_r)
        ST_IDLE: begin
          if (single_s) begin
            cand_s = tot_code_s;
            cnt_s  = 4'd1;
            if (DebOne) begin
              key_s   = tot_code_s;
              valid_s = 1'b1;
              held_s  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_s   = 8'd0;
`endif
            end else begin
              held_s  = held_r;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_PRESS_DB: begin
          if (single_s && same_s) begin
            cnt_s = cnt_inc_s;
            if (at_deb_s) begin
              key_s   = cand_r;
              valid_s = 1'b1;
              held_s  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_s   = 8'd0;
`endif
            end else begin
              held_s  = held_r;
            end
          end else if (single_s) begin
            cand_s = tot_code_s;
            cnt_s  = 4'd1;
          end else begin
            cnt_s  = cnt_r;
          end
        end
        ST_HELD: begin
          if (single_s) begin
`ifdef KEYPAD_REPEAT_EN
            // Repeat counter runs only while the key stays in HELD.
            if ((rep_r + 8'd1) >= RepN) begin
              rep_s   = 8'd0;
              valid_s = 1'b1;
            end else begin
              rep_s   = rep_r + 8'd1;
            end
`else
            cnt_s = cnt_r;
`endif
          end else begin
            cnt_s = 4'd1;
            if (DebOne) begin
              held_s = 1'b0;
            end else begin
              held_s = held_r;
            end
          end
        end
        ST_REL_DB: begin
          if (single_s) begin
            cnt_s = cnt_r;
          end else begin
            cnt_s = cnt_inc_s;
            if (at_deb_s) begin
              held_s = 1'b0;
            end else begin
              held_s = held_r;
            end
          end
        end
        default: begin
          cnt_s = 4'd0;
        end
      endcase
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Data registers behind the FSM, including the registered outputs.
  always_ff @(posedge ClkIn) begin
    if (Rst) begin
      cand_r  <= 4'h0;
      cnt_r   <= 4'd0;
      key_r   <= 4'h0;
      valid_r <= 1'b0;
      held_r  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_r   <= 8'd0;
`endif
    end else begin
      cand_r  <= cand_s;
      cnt_r   <= cnt_s;
      key_r   <= key_s;
      valid_r <= valid_s;
      held_r  <= held_s;
`ifdef KEYPAD_REPEAT_EN
      rep_r   <= rep_s;
`endif
    end
  end

  assign Col      = col_r;
  assign Key      = key_r;
  assign KeyValid = valid_r;
  assign KeyHeld  = held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  localparam int D = 2;
  localparam int R = 3;

  logic        ClkIn = 1'b0;
  logic        Rst   = 1'b1;
  logic [3:0]  Row;
  logic [3:0]  Col;
  logic [3:0]  Key;
  logic        KeyValid;
  logic        KeyHeld;
  logic [15:0] pressed = 16'h0000;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] mask;
    logic        v;
    logic [3:0]  key;
    logic        held;
  } vec_t;

  // behavioural model state (scan-level view)
  bit         m_held;
  int         m_run_key, m_run_len, m_none, m_rep;
  logic [3:0] m_key;

  always #5 ClkIn = ~ClkIn;

  keypad_scanner #(.ScanDiv(4), .Bits(3), .DebounceScans(D), .RepeatScans(R)) dut (
    .ClkIn(ClkIn), .Rst(Rst), .Row(Row), .Col(Col),
    .Key(Key), .KeyValid(KeyValid), .KeyHeld(KeyHeld)
  );

  function automatic logic [3:0] pad_code(input int c, input int r);
    logic [3:0] t [16];
    t = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
          4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};
    return t[c * 4 + r];
  endfunction

  // keypad: a pressed key pulls its row low while its column is driven low
  always_comb begin
    Row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!Col[c] && pressed[pad_code(c, r)]) Row[r] = 1'b0;
  end

  // KeyValid may only appear in the cycle right after a full scan, never twice in a row
  logic [3:0] mon_prev = 4'b1110;
  logic       mon_prev_v = 1'b0;
  always @(negedge ClkIn) begin
    if (KeyValid) begin
      checks++;
      if (!(mon_prev == 4'b0111 && Col == 4'b1110) || mon_prev_v) begin
        failures++;
        $display("FAIL strobe_position actual col=%b prev=%b prev_valid=%b required=scan boundary single pulse",
                 Col, mon_prev, mon_prev_v);
      end
    end
    mon_prev   = Col;
    mon_prev_v = KeyValid;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_boundary();
    logic [3:0] prev;
    bit hit;
    prev = Col;
    hit  = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge ClkIn);
      if (Col == 4'b1110 && prev == 4'b0111) hit = 1'b1;
      prev = Col;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL boundary_timeout actual=no scan boundary required=boundary within 40 clocks");
    end
  endtask

  task automatic run_scan(input string name, input logic [15:0] mask,
                          input logic ev, input logic [3:0] ek, input logic eh);
    pressed = mask;
    wait_boundary();
    check({name, "_valid"}, {15'd0, KeyValid}, {15'd0, ev});
    check({name, "_key"},   {12'd0, Key},      {12'd0, ek});
    check({name, "_held"},  {15'd0, KeyHeld},  {15'd0, eh});
  endtask

  // spec rules at scan granularity: runs of identical SINGLE results accept,
  // runs of NONE (or MULTI) results release
  task automatic model_scan(input logic [15:0] mask, output logic ev);
    int n, k;
    n  = $countones(mask);
    k  = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) k = i;
    ev = 1'b0;
    if (!m_held) begin
      if (n == 1) begin
        if (m_run_len > 0 && k == m_run_key) m_run_len++;
        else begin m_run_key = k; m_run_len = 1; end
        if (m_run_len >= D) begin
          m_held = 1'b1; m_key = 4'(k); ev = 1'b1; m_rep = 0; m_none = 0;
        end
      end else m_run_len = 0;
    end else begin
      if (n != 1) begin
        m_none++;
        if (m_none >= D) begin m_held = 1'b0; m_none = 0; m_run_len = 0; end
      end else begin
`ifdef KEYPAD_REPEAT_EN
        if (m_none == 0) begin
          m_rep++;
          if (m_rep == R) begin m_rep = 0; ev = 1'b1; end
        end
`endif
        m_none = 0;
      end
    end
  endtask

  initial begin
    vec_t       tbl [32];
    logic [3:0] col_pat [4];
    logic       ev, exp_v;
    int         ntbl, cur, other, sel;
    logic [15:0] mask;

    col_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    ntbl = 0;
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h0, 1'b0};
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h0, 1'b0};
    tbl[ntbl++] = '{16'h0200, 1'b0, 4'h0, 1'b0};  // 9 first scan
    tbl[ntbl++] = '{16'h0200, 1'b1, 4'h9, 1'b1};  // 9 accepted
    tbl[ntbl++] = '{16'h0200, 1'b0, 4'h9, 1'b1};
    tbl[ntbl++] = '{16'h0200, 1'b0, 4'h9, 1'b1};
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h9, 1'b1};
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h9, 1'b0};  // released, Key stays 9
    tbl[ntbl++] = '{16'h0020, 1'b0, 4'h9, 1'b0};  // 5 bounce
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h9, 1'b0};
    tbl[ntbl++] = '{16'h0020, 1'b0, 4'h9, 1'b0};
    tbl[ntbl++] = '{16'h0020, 1'b1, 4'h5, 1'b1};
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h5, 1'b1};
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h5, 1'b0};
    tbl[ntbl++] = '{16'h2002, 1'b0, 4'h5, 1'b0};  // 1 + D : MULTI
    tbl[ntbl++] = '{16'h2002, 1'b0, 4'h5, 1'b0};
    tbl[ntbl++] = '{16'h0002, 1'b0, 4'h5, 1'b0};
    tbl[ntbl++] = '{16'h0002, 1'b1, 4'h1, 1'b1};
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h1, 1'b1};
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h1, 1'b0};
    tbl[ntbl++] = '{16'h0004, 1'b0, 4'h1, 1'b0};
    tbl[ntbl++] = '{16'h0004, 1'b1, 4'h2, 1'b1};
    tbl[ntbl++] = '{16'h0008, 1'b0, 4'h2, 1'b1};  // other key while held
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h2, 1'b1};
    tbl[ntbl++] = '{16'h0008, 1'b0, 4'h2, 1'b1};  // back to held, no strobe
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h2, 1'b1};
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h2, 1'b0};
    tbl[ntbl++] = '{16'h0010, 1'b0, 4'h2, 1'b0};  // candidate 4
    tbl[ntbl++] = '{16'h0080, 1'b0, 4'h2, 1'b0};  // candidate replaced by 7
    tbl[ntbl++] = '{16'h0080, 1'b1, 4'h7, 1'b1};
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h7, 1'b1};
    tbl[ntbl++] = '{16'h0000, 1'b0, 4'h7, 1'b0};

    // reset, then idle column walk
    repeat (3) @(negedge ClkIn);
    Rst = 1'b0;
    check("reset_key",   {12'd0, Key},     16'h0);
    check("reset_held",  {15'd0, KeyHeld}, 16'h0);
    for (int s = 0; s < 16; s++) begin
      check("idle_col",   {12'd0, Col},      {12'd0, col_pat[(s / 4) % 4]});
      check("idle_valid", {15'd0, KeyValid}, 16'h0);
      if (s < 15) @(negedge ClkIn);
    end

    for (int i = 0; i < ntbl; i++)
      run_scan($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].v, tbl[i].key, tbl[i].held);

    // reset in the middle of a press debounce
    run_scan("rst_pre", 16'h0200, 1'b0, 4'h7, 1'b0);
    for (int i = 0; i < 20 && Col != 4'b1011; i++) @(negedge ClkIn);
    check("rst_at_col2", {12'd0, Col}, 16'hB);
    Rst = 1'b1;
    @(negedge ClkIn);
    Rst = 1'b0;
    check("rst_col",   {12'd0, Col},      16'hE);
    check("rst_held",  {15'd0, KeyHeld},  16'h0);
    check("rst_valid", {15'd0, KeyValid}, 16'h0);
    check("rst_key",   {12'd0, Key},      16'h0);
    run_scan("rst_db1", 16'h0200, 1'b0, 4'h0, 1'b0);
    run_scan("rst_db2", 16'h0200, 1'b1, 4'h9, 1'b1);
    run_scan("rst_rel1", 16'h0000, 1'b0, 4'h9, 1'b1);
    run_scan("rst_rel2", 16'h0000, 1'b0, 4'h9, 1'b0);

    // hold F: one strobe, plus repeats every R scans when enabled
    for (int i = 0; i < 11; i++) begin
`ifdef KEYPAD_REPEAT_EN
      exp_v = (i == 1) || (i > 1 && (i - 1) % R == 0);
`else
      exp_v = (i == 1);
`endif
      run_scan($sformatf("holdF%0d", i), 16'h8000, exp_v,
               (i >= 1) ? 4'hF : 4'h9, (i >= 1) ? 1'b1 : 1'b0);
    end
    run_scan("relF1", 16'h0000, 1'b0, 4'hF, 1'b1);
    run_scan("relF2", 16'h0000, 1'b0, 4'hF, 1'b0);

    // randomized scans against the model
    m_held = 1'b0; m_run_key = 0; m_run_len = 0; m_none = 0; m_rep = 0; m_key = 4'hF;
    cur = $urandom_range(0, 15);
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) mask = 16'h0000;
      else if (sel < 8) mask = 16'h0001 << cur;
      else if (sel == 8) begin
        cur  = $urandom_range(0, 15);
        mask = 16'h0001 << cur;
      end else begin
        other = (cur + 1 + $urandom_range(0, 14)) % 16;
        mask  = (16'h0001 << cur) | (16'h0001 << other);
      end
      model_scan(mask, ev);
      run_scan($sformatf("rnd%0d", n), mask, ev, m_key, m_held);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
